// File: rtl/sha256_k_pkg.sv
// Shared constants, FSM state type and lane-select helper for the
// SHA-256 round-constant fetch block.
package sha256_k_pkg;

  localparam int NUM_ROUNDS = 64;
  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = 128;
  localparam int WORD_W     = 32;
  localparam int LANE_W     = $clog2(LINE_WORDS);

  // First and last round constants, handy as sanity anchors.
  localparam logic [WORD_W-1:0] K_FIRST = 32'h428a2f98;
  localparam logic [WORD_W-1:0] K_LAST  = 32'hc67178f2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Lane i of a RAM line occupies bits 32i+31:32i.
  function automatic logic [WORD_W-1:0] lane_select(
    input logic [LINE_W-1:0] line,
    input logic [LANE_W-1:0] lane
  );
    return line[int'(lane)*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/sha256_k_linebuf.sv
// Two-entry line FIFO between the RAM read port and the K word stream.
// The head line is exposed one 32-bit lane at a time.
module sha256_k_linebuf
  import sha256_k_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [LINE_W-1:0] push_data,
  input  logic              pop,
  input  logic [LANE_W-1:0] lane,
  output logic [1:0]        count,
  output logic [WORD_W-1:0] lane_word
);

  logic [LINE_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_pop    = pop && (count != 2'd0);
  assign do_push   = push && ((count != 2'd2) || do_pop);
  assign lane_word = lane_select(mem[rd_ptr], lane);

  // Storage, pointers and occupancy; flush discards everything buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sha256_k_fetch.sv
// Avalon-MM read master that pulls the 16 K-constant lines from the
// round-constant RAM and streams the 64 K words to the round engine.
// At most two lines are ever buffered or in flight, so the line FIFO
// cannot overflow even though responses arrive at a fixed latency.
module sha256_k_fetch #(
  parameter int NUM_ROUNDS   = 64,
  parameter int LINE_WORDS   = 4,
  parameter int ADDR_W       = 4,
  parameter int BASE_ADDR    = 0,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              k_valid,
  input  logic              k_ready,
  output logic [31:0]       k_data,
  output logic [5:0]        k_index,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [15:0]       avm_byteenable,
  output logic              avm_clken,
  input  logic [127:0]      avm_readdata
);
  import sha256_k_pkg::*;

  localparam int NUM_LINES = NUM_ROUNDS / LINE_WORDS;
  localparam int ISSUE_W   = $clog2(NUM_LINES) + 1;
  localparam int IDX_W     = 6;

  state_t                  state;
  logic [ISSUE_W-1:0]      issue_cnt;
  logic [IDX_W-1:0]        word_cnt;
  logic [LANE_W-1:0]       lane_ptr;
  logic [READ_LATENCY-1:0] rd_pipe;
  logic [1:0]              buf_count;
  logic [WORD_W-1:0]       lane_word;
  int                      occupancy;
  logic                    want_issue;
  logic                    issue;
  logic                    capture;
  logic                    handshake;
  logic                    last_lane;
  logic                    last_word;
  logic                    pop;

  // Credit: lines sitting in the FIFO plus reads still travelling back.
  assign occupancy  = int'(buf_count) + $countones(rd_pipe);
  // The first read goes out in the start cycle itself so word 0 is valid two cycles later.
  assign want_issue = ((state == S_IDLE) && start) || (state == S_RUN);
  assign issue      = want_issue && !abort && (occupancy < 2) &&
                      (issue_cnt < ISSUE_W'(NUM_LINES));
  assign capture    = rd_pipe[READ_LATENCY-1];

  assign k_valid    = (buf_count != 2'd0);
  assign handshake  = k_valid && k_ready;
  assign last_lane  = (lane_ptr == LANE_W'(LINE_WORDS - 1));
  assign pop        = handshake && last_lane;
  assign last_word  = handshake && (word_cnt == IDX_W'(NUM_ROUNDS - 1));

  assign k_data     = k_valid ? lane_word : '0;
  assign k_index    = word_cnt;

  assign avm_chipselect = issue;
  assign avm_address    = ADDR_W'(BASE_ADDR) + ADDR_W'(issue_cnt);
  assign avm_write      = 1'b0;
  assign avm_byteenable = 16'hffff;
  assign avm_clken      = 1'b1;

  sha256_k_linebuf u_linebuf (
    .clk       (clk),
    .rst       (reset),
    .flush     (abort),
    .push      (capture),
    .push_data (avm_readdata),
    .pop       (pop),
    .lane      (lane_ptr),
    .count     (buf_count),
    .lane_word (lane_word)
  );

  // Run sequencing: FSM, issue/word/lane counters, in-flight tracking, busy and done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      issue_cnt <= '0;
      word_cnt  <= '0;
      lane_ptr  <= '0;
      rd_pipe   <= '0;
    end else if (abort) begin
      // Clearing rd_pipe drops any response still on its way back.
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      issue_cnt <= '0;
      word_cnt  <= '0;
      lane_ptr  <= '0;
      rd_pipe   <= '0;
    end else begin
      done    <= 1'b0;
      rd_pipe <= (rd_pipe << 1) | READ_LATENCY'(issue);
      if (issue) begin
        issue_cnt <= issue_cnt + ISSUE_W'(1);
      end
      if (handshake) begin
        word_cnt <= word_cnt + IDX_W'(1);
        lane_ptr <= last_lane ? '0 : lane_ptr + LANE_W'(1);
      end
      case (state)
        S_IDLE: begin
          word_cnt <= '0;
          lane_ptr <= '0;
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (issue && (issue_cnt == ISSUE_W'(NUM_LINES - 1))) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last_word) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            issue_cnt <= '0;
            word_cnt  <= '0;
            lane_ptr  <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_k_fetch.sv
// Scoreboard bench for sha256_k_fetch: starts push the expected K stream,
// a negedge monitor pops and compares on every handshake.
`timescale 1ns/1ps
module tb_sha256_k_fetch;

  logic         clk = 1'b0;
  logic         reset, start, abort, k_ready;
  logic         busy, done, k_valid;
  logic [31:0]  k_data;
  logic [5:0]   k_index;
  logic [3:0]   avm_address;
  logic         avm_chipselect, avm_write, avm_clken;
  logic [15:0]  avm_byteenable;
  logic [127:0] avm_readdata;

  always #5 clk = ~clk;

  sha256_k_fetch #(
    .NUM_ROUNDS(64), .LINE_WORDS(4), .ADDR_W(4), .BASE_ADDR(0), .READ_LATENCY(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done),
    .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data), .k_index(k_index),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_clken(avm_clken), .avm_readdata(avm_readdata)
  );

  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct packed { logic [31:0] data; logic [5:0] idx; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, first_cyc = -1, done_cyc = -1, done_count = 0;
  int rd_issued = 0, hs_in_run = 0, ready_mode = 0, d0 = 0;
  logic        stalled_prev = 1'b0;
  logic [31:0] prev_data = '0;
  logic [5:0]  prev_idx = '0;
  logic [31:0] got_words [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle counter used for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered read, one cycle latency, line i holds K[4i..4i+3]
  always @(posedge clk)
    if (avm_chipselect)
      avm_readdata <= {k_tab[{avm_address, 2'd3}], k_tab[{avm_address, 2'd2}],
                       k_tab[{avm_address, 2'd1}], k_tab[{avm_address, 2'd0}]};

  // Ready driver: 0 = always ready, 1 = random 50%, 2 = held low
  initial begin
    k_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: k_ready = 1'b1;
        1: k_ready = 1'($urandom_range(0, 1));
        default: k_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pops, stall stability, read address and credit checks
  always @(negedge clk) begin
    if (reset) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        check("stall_valid", 64'(k_valid), 64'd1);
        check("stall_data", 64'(k_data), 64'(prev_data));
        check("stall_index", 64'(k_index), 64'(prev_idx));
      end
      if (k_valid && first_cyc < 0) first_cyc = cyc;
      if (avm_chipselect) begin
        check("read_addr", 64'(avm_address), 64'(rd_issued));
        check("credit_le2", 64'((rd_issued - hs_in_run / 4) < 2), 64'd1);
        rd_issued++;
      end
      if (k_valid && k_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got idx %0d data 0x%0h expected no word", k_index, k_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("k_data", 64'(k_data), 64'(mon_e.data));
          check("k_index", 64'(k_index), 64'(mon_e.idx));
        end
        if (hs_in_run < 4) got_words[hs_in_run] = k_data;
        hs_in_run++;
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
        check("queue_empty_at_done", 64'(exp_q.size()), 64'd0);
      end
      stalled_prev = k_valid && !k_ready;
      prev_data    = k_data;
      prev_idx     = k_index;
    end
  end

  task automatic do_start();
    @(posedge clk); #1;
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back('{data: k_tab[i], idx: 6'(i)});
    rd_issued = 0;
    hs_in_run = 0;
    first_cyc = -1;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int base;
    base = done_count;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_count > base) break;
    end
    check("done_within_budget", 64'(done_count > base), 64'd1);
  endtask

  task automatic wait_index(input int idx, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (k_valid && k_index == 6'(idx)) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach_index", 64'(hit), 64'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; avm_readdata = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_k_valid", 64'(k_valid), 64'd0);
    check("rst_k_data", 64'(k_data), 64'd0);
    check("rst_k_index", 64'(k_index), 64'd0);
    check("rst_cs", 64'(avm_chipselect), 64'd0);
    check("rst_addr", 64'(avm_address), 64'd0);
    check("tie_write", 64'(avm_write), 64'd0);
    check("tie_be", 64'(avm_byteenable), 64'hffff);
    check("tie_clken", 64'(avm_clken), 64'd1);
    @(negedge clk); reset = 1'b0;

    // Full run with k_ready held high
    ready_mode = 0;
    d0 = done_count;
    do_start();
    wait_done(200);
    check("first_valid_cycle", 64'(first_cyc - start_cyc), 64'd2);
    check("start_to_done", 64'(done_cyc - start_cyc), 64'd66);
    check("done_once", 64'(done_count - d0), 64'd1);
    check("lane0", 64'(got_words[0]), 64'h428a2f98);
    check("lane1", 64'(got_words[1]), 64'h71374491);
    check("lane2", 64'(got_words[2]), 64'hb5c0fbcf);
    check("lane3", 64'(got_words[3]), 64'he9b5dba5);
    @(negedge clk);
    check("done_pulse_width", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_k_valid", 64'(k_valid), 64'd0);

    // k_ready low for 20 cycles after start
    ready_mode = 2;
    @(posedge clk);
    do_start();
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("stall_reads", 64'(rd_issued), 64'd2);
    check("stall_head_index", 64'(k_index), 64'd0);
    check("stall_busy", 64'(busy), 64'd1);
    ready_mode = 0;
    wait_done(300);
    check("stall_run_words", 64'(hs_in_run), 64'd64);

    // Random 50% backpressure
    ready_mode = 1;
    do_start();
    wait_done(1000);
    check("random_run_words", 64'(hs_in_run), 64'd64);
    ready_mode = 0;

    // Abort at k_index 37 while a read is in flight, then restart
    do_start();
    wait_index(37, 200);
    d0 = done_count;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_k_valid", 64'(k_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
    check("abort_drop_inflight", 64'(k_valid), 64'd0);
    check("abort_no_done", 64'(done_count - d0), 64'd0);
    do_start();
    wait_done(200);
    check("restart_k0", 64'(got_words[0]), 64'h428a2f98);
    check("restart_words", 64'(hs_in_run), 64'd64);

    // start while busy is ignored
    d0 = done_count;
    do_start();
    wait_index(10, 200);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);
    repeat (5) @(posedge clk);
    check("midrun_start_done_once", 64'(done_count - d0), 64'd1);
    check("midrun_start_words", 64'(hs_in_run), 64'd64);

    // Reset mid-run at k_index 20
    d0 = done_count;
    do_start();
    wait_index(20, 200);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_k_valid", 64'(k_valid), 64'd0);
    check("mid_rst_k_data", 64'(k_data), 64'd0);
    check("mid_rst_k_index", 64'(k_index), 64'd0);
    check("mid_rst_cs", 64'(avm_chipselect), 64'd0);
    check("mid_rst_addr", 64'(avm_address), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (10) @(posedge clk);
    #1;
    check("mid_rst_no_done", 64'(done_count - d0), 64'd0);
    check("mid_rst_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
